inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 23 ++
 rtl/inst_fetch.sv | 116 +++++++++++
 tb/tb_inst_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory port: fetch request, memory response and response consume strobe.
// master = fetch unit, slave = instruction memory.
interface inst_fetch_if;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic        valid;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

  memory_io_req inst_mem_req;
  memory_io_rsp inst_mem_rsp;
  logic         inst_mem_req_ack;

  modport master (output inst_mem_req, output inst_mem_req_ack, input inst_mem_rsp);
  modport slave  (input inst_mem_req, input inst_mem_req_ack, output inst_mem_rsp);
endinterface

// File: rtl/inst_fetch.sv
// Single-entry instruction fetch unit: one outstanding memory read, one buffered
// instruction toward the core, with redirect (branch/jump) flushing.
//
// state | meaning
// IDLE  | out of reset, loads fetch_pc from reset_pc (or redirect_pc)
// REQ   | request valid on the memory port for fetch_pc
// WAIT  | request accepted, waiting for the response
// FULL  | instruction buffered and presented to the core
module inst_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reset_pc,
  inst_fetch_if.master mem,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] instr_nx, instr_pc_nx;
  logic [31:0] addr_q;
  logic        drop, drop_nx;
  logic        rsp_valid;
  logic [31:0] redirect_pc_al;

  assign rsp_valid      = mem.inst_mem_rsp.valid;
  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= 32'h0;
      drop     <= 1'b0;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
      addr_q   <= 32'h0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      drop     <= drop_nx;
      instr    <= instr_nx;
      instr_pc <= instr_pc_nx;
      if (state == REQ) addr_q <= fetch_pc;
    end
  end

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    drop_nx     = drop;
    instr_nx    = instr;
    instr_pc_nx = instr_pc;
    case (state)
      IDLE: begin
        state_nx    = REQ;
        fetch_pc_nx = redirect ? redirect_pc_al : reset_pc;
      end
      REQ: begin
        // the request already on the bus still goes out; its data is dropped later
        state_nx = WAIT;
        if (redirect) begin
          drop_nx     = 1'b1;
          fetch_pc_nx = redirect_pc_al;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          if (redirect) begin
            fetch_pc_nx = redirect_pc_al;
            drop_nx     = 1'b0;
            state_nx    = REQ;
          end else if (drop) begin
            drop_nx  = 1'b0;
            state_nx = REQ;
          end else begin
            instr_nx    = mem.inst_mem_rsp.data;
            instr_pc_nx = fetch_pc;
            fetch_pc_nx = fetch_pc + 32'd4;
            state_nx    = FULL;
          end
        end else if (redirect) begin
          drop_nx     = 1'b1;
          fetch_pc_nx = redirect_pc_al;
        end
      end
      FULL: begin
        // redirect wins over a same-cycle handshake: the buffered word is discarded
        if (redirect) begin
          fetch_pc_nx = redirect_pc_al;
          state_nx    = REQ;
        end else if (instr_ready) begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem.inst_mem_req.addr     = (state == REQ) ? fetch_pc : addr_q;
    mem.inst_mem_req.data     = 32'h0;
    mem.inst_mem_req.do_read  = 4'b1111;
    mem.inst_mem_req.do_write = 4'b0000;
    mem.inst_mem_req.valid    = (state == REQ);
    mem.inst_mem_req_ack      = (state == WAIT) && rsp_valid;
  end

  assign instr_valid = (state == FULL);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table-driven fetch vectors, directed multi-cycle corner
// cases, and a randomized run against a program-order reference model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reset_pc, instr, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect;

  inst_fetch_if mem();

  inst_fetch dut (
    .clk(clk), .reset(reset), .reset_pc(reset_pc), .mem(mem),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model state
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          mem_lat;
  bit          lat_rand;
  bit          fixed_en;
  logic [31:0] fixed_data;

  // drive values and per-cycle samples
  bit          drv_ready, drv_redirect;
  logic [31:0] drv_rpc;
  bit          s_rsp, s_rv, s_ack, s_iv;
  logic [31:0] s_addr, s_instr, s_ipc;
  int          cyc;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] data;
    logic [31:0] a0, a1, a2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (fixed_en) return fixed_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cycle();
    @(negedge clk);
    instr_ready = drv_ready;
    redirect    = drv_redirect;
    redirect_pc = drv_rpc;
    s_rsp = mem_busy && (mem_cnt == 0);
    mem.inst_mem_rsp.valid = s_rsp;
    mem.inst_mem_rsp.data  = s_rsp ? mem_data(mem_addr) : 32'hBAD0_BAD0;
    #1;
    s_rv    = mem.inst_mem_req.valid;
    s_addr  = mem.inst_mem_req.addr;
    s_ack   = mem.inst_mem_req_ack;
    s_iv    = instr_valid;
    s_instr = instr;
    s_ipc   = instr_pc;
    chk("ack_vs_rsp", {31'b0, s_ack}, {31'b0, s_rsp});
    chk("req_rw", {24'b0, mem.inst_mem_req.do_read, mem.inst_mem_req.do_write}, 32'h0000_00F0);
    chk("req_data", mem.inst_mem_req.data, 32'h0);
    if (s_rsp && s_ack) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (s_rv) begin
      chk("one_outstanding", {31'b0, mem_busy}, 32'h0);
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt  = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
    end
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    reset = 1'b0;
    mem_busy = 1'b0;
    mem.inst_mem_rsp.valid = 1'b0;
    drv_ready = 1'b0; drv_redirect = 1'b0; drv_rpc = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0;
    reset_pc = pc;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(input string name, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (s_rv) found = 1'b1;
    end
    chk({name, "_req_timeout"}, {31'b0, found}, 32'h1);
  endtask

  task automatic wait_instr(input string name, output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (s_iv) found = 1'b1;
    end
    chk({name, "_instr_timeout"}, {31'b0, found}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] a[3];
    int          c[3];
    int          nreq;
    bit          got;
    logic [31:0] gi, gp;
    nreq = 0; got = 1'b0; gi = 32'h0; gp = 32'h0;
    fixed_en = 1'b1; fixed_data = v.data; lat_rand = 1'b0; mem_lat = 0;
    do_reset(v.rpc);
    drv_ready = 1'b1;
    for (int k = 0; k < 30 && nreq < 3; k++) begin
      cycle();
      if (s_rv) begin
        a[nreq] = s_addr; c[nreq] = cyc; nreq++;
      end
      if (s_iv && !got) begin
        got = 1'b1; gi = s_instr; gp = s_ipc;
      end
    end
    chk("vec_nreq", nreq, 3);
    if (nreq == 3) begin
      chk("vec_addr0", a[0], v.a0);
      chk("vec_addr1", a[1], v.a1);
      chk("vec_addr2", a[2], v.a2);
      chk("vec_gap01", c[1] - c[0], 3);
      chk("vec_gap12", c[2] - c[1], 3);
    end
    chk("vec_got_instr", {31'b0, got}, 32'h1);
    chk("vec_instr", gi, v.data);
    chk("vec_instr_pc", gp, v.a0);
    fixed_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    bit          found, leaked, saw_ack, hit;
    logic [31:0] hold_i, hold_pc, exp_pc, rp;
    int          consumed;

    reset = 1'b0; reset_pc = 32'h0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem.inst_mem_rsp.valid = 1'b0; mem.inst_mem_rsp.data = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0; mem_lat = 0; lat_rand = 1'b0;
    fixed_en = 1'b0; fixed_data = 32'h0; drv_ready = 1'b0; drv_redirect = 1'b0; drv_rpc = 32'h0;
    cyc = 0;

    vecs.push_back('{32'h0000_0100, 32'h0050_0093, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108});
    vecs.push_back('{32'hFFFF_FFFC, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{32'h7FFF_FFF8, 32'hDEAD_BEEF, 32'h7FFF_FFF8, 32'h7FFF_FFFC, 32'h8000_0000});
    vecs.push_back('{32'h0000_1000, 32'h1234_5678, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008});

    // reset state
    #12;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_req_valid", {31'b0, mem.inst_mem_req.valid}, 32'h0);
    chk("rst_req_addr", mem.inst_mem_req.addr, 32'h0);
    chk("rst_ack", {31'b0, mem.inst_mem_req_ack}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // backpressure
    lat_rand = 1'b0; mem_lat = 0;
    do_reset(32'h100);
    drv_ready = 1'b0;
    wait_instr("bp", found);
    hold_i = s_instr; hold_pc = s_ipc;
    chk("bp_pc", hold_pc, 32'h100);
    chk("bp_instr", hold_i, mem_data(32'h100));
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_valid", {31'b0, s_iv}, 32'h1);
      chk("bp_instr_hold", s_instr, hold_i);
      chk("bp_pc_hold", s_ipc, hold_pc);
      chk("bp_no_req", {31'b0, s_rv}, 32'h0);
      chk("bp_addr_hold", s_addr, 32'h100);
    end
    drv_ready = 1'b1;
    cycle();
    chk("bp_accept_valid", {31'b0, s_iv}, 32'h1);
    drv_ready = 1'b0;
    cycle();
    chk("bp_next_req", {31'b0, s_rv}, 32'h1);
    chk("bp_next_addr", s_addr, 32'h104);

    // redirect while waiting, response 4 cycles later
    mem_lat = 4;
    do_reset(32'h100);
    drv_ready = 1'b1;
    wait_req("rdw", found);
    chk("rdw_first_addr", s_addr, 32'h100);
    drv_redirect = 1'b1; drv_rpc = 32'h200;
    cycle();
    drv_redirect = 1'b0; mem_lat = 0;
    found = 1'b0; leaked = 1'b0; saw_ack = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_rsp && s_ack) saw_ack = 1'b1;
      if (s_iv) leaked = 1'b1;
      if (s_rv) found = 1'b1;
    end
    chk("rdw_req_found", {31'b0, found}, 32'h1);
    chk("rdw_ack_seen", {31'b0, saw_ack}, 32'h1);
    chk("rdw_no_stale", {31'b0, leaked}, 32'h0);
    chk("rdw_next_addr", s_addr, 32'h200);
    wait_instr("rdw", found);
    chk("rdw_instr_pc", s_ipc, 32'h200);
    chk("rdw_instr", s_instr, mem_data(32'h200));

    // redirect coincident with the response
    mem_lat = 2;
    do_reset(32'h100);
    drv_ready = 1'b1;
    wait_req("sim", found);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (mem_busy && mem_cnt == 0) begin
        drv_redirect = 1'b1; drv_rpc = 32'h3FE; hit = 1'b1;
      end
      cycle();
      drv_redirect = 1'b0;
    end
    chk("sim_hit", {31'b0, hit}, 32'h1);
    chk("sim_ack", {31'b0, s_ack}, 32'h1);
    mem_lat = 0;
    found = 1'b0; leaked = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_iv) leaked = 1'b1;
      if (s_rv) found = 1'b1;
    end
    chk("sim_req_found", {31'b0, found}, 32'h1);
    chk("sim_no_stale", {31'b0, leaked}, 32'h0);
    chk("sim_next_addr", s_addr, 32'h3FC);
    wait_instr("sim", found);
    chk("sim_instr_pc", s_ipc, 32'h3FC);
    chk("sim_instr", s_instr, mem_data(32'h3FC));

    // asynchronous reset in WAIT
    mem_lat = 0;
    do_reset(32'h500);
    drv_ready = 1'b0;
    wait_instr("mrst", found);
    drv_ready = 1'b1; mem_lat = 6;
    cycle();
    wait_req("mrst", found);
    chk("mrst_addr", s_addr, 32'h504);
    cycle();
    cycle();
    #1;
    mem.inst_mem_rsp.valid = 1'b1;
    mem.inst_mem_rsp.data  = 32'hCAFE_F00D;
    #1;
    chk("mrst_pre_ack", {31'b0, mem.inst_mem_req_ack}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mrst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("mrst_req_valid", {31'b0, mem.inst_mem_req.valid}, 32'h0);
    chk("mrst_req_addr", mem.inst_mem_req.addr, 32'h0);
    chk("mrst_ack", {31'b0, mem.inst_mem_req_ack}, 32'h0);
    chk("mrst_instr", instr, 32'h0);
    chk("mrst_instr_pc", instr_pc, 32'h0);
    mem_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h900; instr_ready = 1'b1;
      #1;
      chk("mrst_hold_ack", {31'b0, mem.inst_mem_req_ack}, 32'h0);
      chk("mrst_hold_valid", {31'b0, instr_valid | mem.inst_mem_req.valid}, 32'h0);
    end
    @(negedge clk);
    mem.inst_mem_rsp.valid = 1'b0;
    drv_redirect = 1'b0; drv_ready = 1'b1; mem_lat = 0;
    redirect = 1'b0;
    reset_pc = 32'h600;
    reset = 1'b1;
    wait_req("mrst_rel", found);
    chk("mrst_rel_addr", s_addr, 32'h600);

    // randomized run against program-order model
    lat_rand = 1'b1;
    rp = $urandom;
    do_reset(rp);
    exp_pc = rp;
    consumed = 0;
    for (int k = 0; k < 3000; k++) begin
      drv_ready    = ($urandom_range(0, 3) != 0);
      drv_redirect = ($urandom_range(0, 15) == 0);
      drv_rpc      = $urandom;
      cycle();
      if (drv_redirect) begin
        exp_pc = drv_rpc & 32'hFFFF_FFFC;
      end else if (s_iv && drv_ready) begin
        chk("rand_pc", s_ipc, exp_pc);
        chk("rand_instr", s_instr, mem_data(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    chk("rand_progress", {31'b0, consumed > 100}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
